regfile_nrd: RTL and testbench

- Parametrised general-purpose register file: one write port, NUM_RD independent read ports.
- Successor to the fixed 32-entry, 32-bit, single-read selector. Adds:
  - parametrised depth, width and read-port count;
  - per-port read enable;
  - optional hardwired-zero entry;
  - write-to-read bypass;
  - optional registered read stage.
- Sits in the decode stage of the MIPS pipeline. Feeds rs/rt operands; written back from the WB stage.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rd_port.sv | 68 ++++++
 rtl/regfile_nrd.sv | 70 +++++++
 tb/tb_regfile_nrd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file and its read ports.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_IDX = 0;
  localparam int RF_DEPTH    = 2**RF_ADDR_W;

  // READ_LAT encodings
  localparam int RD_COMB = 0;
  localparam int RD_REG  = 1;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of the register file: entry select, write bypass, zero-entry
// forcing and an optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int READ_LAT = RD_COMB,
  parameter int BYPASS   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  mem_i,
  input  logic                           we_i,
  input  logic [ADDR_W-1:0]              waddr_i,
  input  logic [DATA_W-1:0]              wdata_i,
  input  logic                           re_i,
  input  logic [ADDR_W-1:0]              raddr_i,
  output logic [DATA_W-1:0]              rdata_o,
  output logic                           rvalid_o
);

  logic              is_zero;
  logic              bypass_hit;
  logic [DATA_W-1:0] src;

  assign is_zero    = (ZERO_REG != 0) && (raddr_i == ADDR_W'(RF_ZERO_IDX));
  assign bypass_hit = (BYPASS != 0) && we_i && (waddr_i == raddr_i);

  // Zero forcing outranks the bypass so entry 0 can never leak write data.
  always_comb begin
    src = mem_i[raddr_i*DATA_W +: DATA_W];
    if (is_zero) begin
      src = '0;
    end else if (bypass_hit) begin
      src = wdata_i;
    end
  end

  generate
    if (READ_LAT == RD_REG) begin : g_reg
      logic [DATA_W-1:0] rdata_q;
      logic              rvalid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= re_i;
          if (re_i) begin
            rdata_q <= src;
          end
        end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};
      assign rdata_o  = re_i ? src : '0;
      assign rvalid_o = re_i;
    end
  endgenerate

endmodule

// File: rtl/regfile_nrd.sv
// Register file with one write port and NUM_RD independent read ports; holds
// the storage array and write logic, each read port is a regfile_rd_port.
module regfile_nrd
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int READ_LAT = RD_COMB,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH*DATA_W-1:0] mem_q;
  logic [DEPTH*DATA_W-1:0] mem_d;
  logic                    wr_ok;

  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == ADDR_W'(RF_ZERO_IDX)));

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[waddr*DATA_W +: DATA_W] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .READ_LAT (READ_LAT),
        .BYPASS   (BYPASS)
      ) u_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_i    (mem_q),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .re_i     (re[p]),
        .raddr_i  (raddr[p*ADDR_W +: ADDR_W]),
        .rdata_o  (rdata[p*DATA_W +: DATA_W]),
        .rvalid_o (rvalid[p])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_nrd.sv
// Directed bench for regfile_nrd across four parameter configurations, with
// expected values queued on a scoreboard and popped at each sample point.
module tb_regfile_nrd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the three 32-bit, 2-port instances
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] a_rdata, b_rdata, c_rdata;
  logic [1:0]  a_rvalid, b_rvalid, c_rvalid;

  // 16-bit, 8-entry, 4-port instance
  logic        d_we;
  logic [2:0]  d_waddr;
  logic [15:0] d_wdata;
  logic [3:0]  d_re;
  logic [11:0] d_raddr;
  logic [63:0] d_rdata;
  logic [3:0]  d_rvalid;

  // a: defaults (zero reg, comb read, bypass)
  regfile_nrd u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(a_rdata), .rvalid(a_rvalid)
  );

  // b: no zero reg, no bypass, comb read
  regfile_nrd #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(b_rdata), .rvalid(b_rvalid)
  );

  // c: registered read
  regfile_nrd #(.READ_LAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(c_rdata), .rvalid(c_rvalid)
  );

  regfile_nrd #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_d (
    .clk(clk), .rst_n(rst_n), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
    .re(d_re), .raddr(d_raddr), .rdata(d_rdata), .rvalid(d_rvalid)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h01010101 * 32'(i);
  endfunction

  initial begin
    we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    d_we = 1'b0; d_waddr = '0; d_wdata = '0; d_re = '0; d_raddr = '0;

    // registered outputs stay cleared while reset is held, even with re=1
    re = 2'b11; raddr = {5'd5, 5'd5};
    repeat (2) @(negedge clk);
    push(32'h0); check("rst_c_rdata0", c_rdata[31:0]);
    push(32'h0); check("rst_c_rvalid", {30'b0, c_rvalid});
    rst_n = 1'b1; re = 2'b00;

    // asynchronous reset between edges
    wr(5'd5, 32'hDEADBEEF);
    re = 2'b01; raddr = {5'd0, 5'd5};
    #1 push(32'hDEADBEEF); check("pre_rst_a_p0", a_rdata[31:0]);
    #1 rst_n = 1'b0;
    #1 push(32'h0); check("async_rst_a_p0", a_rdata[31:0]);
    push(32'h0); check("async_rst_b_p0", b_rdata[31:0]);
    push(32'h0); check("async_rst_c_rvalid", {30'b0, c_rvalid});
    #1 rst_n = 1'b1;
    @(negedge clk);
    push(32'h0); check("post_rst_c_p0", c_rdata[31:0]);
    push(32'h1); check("post_rst_c_rvalid", {30'b0, c_rvalid});
    re = 2'b00;

    // zero register
    wr(5'd0, 32'h12345678);
    re = 2'b11; raddr = {5'd0, 5'd0};
    #1 push(32'h0); check("zero_a_p0", a_rdata[31:0]);
    push(32'h0); check("zero_a_p1", a_rdata[63:32]);
    push(32'h12345678); check("nozero_b_p0", b_rdata[31:0]);
    push(32'h12345678); check("nozero_b_p1", b_rdata[63:32]);
    @(negedge clk);
    push(32'h0); check("zero_c_p0", c_rdata[31:0]);
    push(32'h0); check("zero_c_p1", c_rdata[63:32]);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    #1 push(32'h0); check("zero_bypass_a_p0", a_rdata[31:0]);
    push(32'h12345678); check("nobypass_old_b_p0", b_rdata[31:0]);
    @(negedge clk);
    we = 1'b0;

    // same-cycle bypass vs read-before-write
    re = 2'b01; raddr = {5'd0, 5'd7};
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    #1 push(32'hA5A5A5A5); check("bypass_a_p0", a_rdata[31:0]);
    push(32'h0); check("re0_a_p1", a_rdata[63:32]);
    push(32'h1); check("rvalid_a", {30'b0, a_rvalid});
    push(32'h0); check("rbw_b_p0", b_rdata[31:0]);
    @(negedge clk);
    we = 1'b0;
    #1 push(32'hA5A5A5A5); check("after_wr_b_p0", b_rdata[31:0]);

    // registered read: capture, hold, and bypass through the register
    re = 2'b00;
    wr(5'd3, 32'h0000CAFE);
    re = 2'b10; raddr = {5'd3, 5'd0};
    @(negedge clk);
    push(32'h0000CAFE); check("reg_c_p1", c_rdata[63:32]);
    push(32'h2); check("reg_c_rvalid", {30'b0, c_rvalid});
    re = 2'b00;
    @(negedge clk);
    push(32'h0000CAFE); check("hold_c_p1", c_rdata[63:32]);
    push(32'h0); check("hold_c_rvalid", {30'b0, c_rvalid});
    re = 2'b10; raddr = {5'd4, 5'd0};
    we = 1'b1; waddr = 5'd4; wdata = 32'h0BADF00D;
    @(negedge clk);
    we = 1'b0;
    push(32'h0BADF00D); check("reg_bypass_c_p1", c_rdata[63:32]);
    push(32'h2); check("reg_bypass_c_rvalid", {30'b0, c_rvalid});
    re = 2'b00;

    // sweep every entry, then read mirrored pairs
    for (int i = 0; i < 32; i++) wr(5'(i), pat(i));
    re = 2'b11;
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #1;
      push((i == 0) ? 32'h0 : pat(i));           check("sweep_a_p0", a_rdata[31:0]);
      push((i == 31) ? 32'h0 : pat(31 - i));     check("sweep_a_p1", a_rdata[63:32]);
      push(pat(i));                               check("sweep_b_p0", b_rdata[31:0]);
      push(pat(31 - i));                          check("sweep_b_p1", b_rdata[63:32]);
      @(negedge clk);
    end
    raddr = {5'd9, 5'd9};
    #1 push(32'h09090909); check("same_addr_a_p0", a_rdata[31:0]);
    push(32'h09090909); check("same_addr_a_p1", a_rdata[63:32]);
    re = 2'b00;

    // narrow, four-port configuration
    @(negedge clk);
    d_we = 1'b1; d_waddr = 3'd7; d_wdata = 16'hBEEF;
    @(negedge clk);
    d_we = 1'b0; d_re = 4'b1111; d_raddr = {4{3'd7}};
    #1;
    for (int p = 0; p < 4; p++) begin
      push(32'h0000BEEF); check("d_all_ports", {16'b0, d_rdata[p*16 +: 16]});
    end
    push(32'hF); check("d_rvalid_all", {28'b0, d_rvalid});
    d_re = 4'b0101;
    #1 push(32'h0000BEEF); check("d_p0_en", {16'b0, d_rdata[15:0]});
    push(32'h0); check("d_p1_dis", {16'b0, d_rdata[31:16]});
    push(32'h0); check("d_p3_dis", {16'b0, d_rdata[63:48]});
    push(32'h5); check("d_rvalid_part", {28'b0, d_rvalid});
    @(negedge clk);
    d_we = 1'b1; d_waddr = 3'd0; d_wdata = 16'h1111;
    d_re = 4'b0001; d_raddr = {3'd7, 3'd7, 3'd7, 3'd0};
    #1 push(32'h0); check("d_zero_bypass", {16'b0, d_rdata[15:0]});
    @(negedge clk);
    d_we = 1'b0;
    #1 push(32'h0); check("d_zero_after_wr", {16'b0, d_rdata[15:0]});

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
